// File: rtl/sram_bus_controller_pkg.sv
// Shared types for the SRAM bus controller: controller state encoding and word-width helper.
package sram_bus_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_ACK       = 2'd2,
        ST_CLEAR     = 2'd3
    } state_t;

    function automatic int word_size(input int byte_count);
        return 8 * byte_count;
    endfunction

endpackage

// File: rtl/sram_clear_engine.sv
// Address walker for the memory clear: steps one word per cycle while running and
// flags the final word so the controller can leave CLEAR.
module sram_clear_engine #(
    parameter int ADDRESS_SIZE = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic [ADDRESS_SIZE-1:0] addr,
    output logic                    last
);

    // Natural wrap after the top word leaves the counter at 0 for the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr <= '0;
        else if (run)
            addr <= addr + ADDRESS_SIZE'(1);
    end

    assign last = &addr;

endmodule

// File: rtl/sram_bus_controller.sv
// Wishbone-classic slave driving the primary RW port of one SRAM bank, with a
// built-in engine that zeroes the whole bank after reset and on request.
module sram_bus_controller
    import sram_bus_controller_pkg::*;
#(
    parameter int  BYTE_COUNT     = 4,
    parameter int  ADDRESS_SIZE   = 9,
    parameter int  BUS_ADDR_SIZE  = 24,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int WORD_SIZE      = word_size(BYTE_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [BYTE_COUNT-1:0]    wb_sel_i,
    input  logic [BUS_ADDR_SIZE-1:0] wb_adr_i,
    input  logic [WORD_SIZE-1:0]     wb_data_i,
    output logic                     wb_ack_o,
    output logic [WORD_SIZE-1:0]     wb_data_o,
    input  logic                     clearStart,
    output logic                     busy,
    output logic                     sramSelect,
    output logic                     sramWriteEnable,
    output logic [BYTE_COUNT-1:0]    sramWriteMask,
    output logic [ADDRESS_SIZE-1:0]  sramAddress,
    output logic [WORD_SIZE-1:0]     sramDataWrite,
    input  logic [WORD_SIZE-1:0]     sramDataRead
);

    state_t                  state, state_next;
    logic                    clear_pending;
    logic                    read_hit;
    logic                    clear_run;
    logic                    clear_last;
    logic [ADDRESS_SIZE-1:0] clear_addr;
    logic                    valid;
    logic                    in_range;
    logic                    hit;
    logic                    unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    if (BUS_ADDR_SIZE > ADDRESS_SIZE + 2) begin : g_hi
        assign in_range = ~|wb_adr_i[BUS_ADDR_SIZE-1:ADDRESS_SIZE+2];
    end else begin : g_nohi
        assign in_range = 1'b1;
    end

    assign valid    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    // Out-of-range addresses and empty writes complete on the bus but never touch the SRAM.
    assign hit      = in_range & (~wb_we_i | (|wb_sel_i));
    assign wb_ack_o = (state == ST_ACK);
    assign busy     = (state == ST_CLEAR);

    sram_clear_engine #(
        .ADDRESS_SIZE(ADDRESS_SIZE)
    ) u_clear (
        .clk (clk),
        .rst (rst),
        .run (clear_run),
        .addr(clear_addr),
        .last(clear_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next      = state;
        clear_run       = 1'b0;
        sramSelect      = 1'b0;
        sramWriteEnable = 1'b0;
        sramWriteMask   = '0;
        sramAddress     = '0;
        sramDataWrite   = '0;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    sramSelect      = hit;
                    sramWriteEnable = wb_we_i;
                    sramWriteMask   = wb_sel_i;
                    sramAddress     = wb_adr_i[ADDRESS_SIZE+1:2];
                    sramDataWrite   = wb_data_i;
                    state_next      = wb_we_i ? ST_ACK : ST_READ_WAIT;
                end else if (clearStart) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_READ_WAIT: state_next = ST_ACK;
            ST_ACK:       state_next = (clear_pending | clearStart) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                clear_run       = 1'b1;
                sramSelect      = 1'b1;
                sramWriteEnable = 1'b1;
                sramWriteMask   = '1;
                sramAddress     = clear_addr;
                if (clear_last)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // The SRAM pins are combinational, so hold them quiet while reset is applied.
        if (rst) begin
            clear_run       = 1'b0;
            sramSelect      = 1'b0;
            sramWriteEnable = 1'b0;
            sramWriteMask   = '0;
            sramAddress     = '0;
            sramDataWrite   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_pending <= 1'b0;
            read_hit      <= 1'b0;
            wb_data_o     <= '0;
        end else begin
            if (state == ST_ACK)
                clear_pending <= 1'b0;
            else if (clearStart && (state == ST_READ_WAIT || (state == ST_IDLE && valid)))
                clear_pending <= 1'b1;
            if (state == ST_IDLE && valid && !wb_we_i)
                read_hit <= hit;
            if (state == ST_READ_WAIT)
                wb_data_o <= read_hit ? sramDataRead : '0;
        end
    end

endmodule

// File: tb/tb_sram_bus_controller.sv
// Directed bench for sram_bus_controller with a small behavioural SRAM on the primary port.
module tb_sram_bus_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [23:0] wb_adr_i;
    logic [31:0] wb_data_i;
    logic        wb_ack_o;
    logic [31:0] wb_data_o;
    logic        clearStart;
    logic        busy;
    logic        sramSelect, sramWriteEnable;
    logic [3:0]  sramWriteMask;
    logic [3:0]  sramAddress;
    logic [31:0] sramDataWrite;
    logic [31:0] sramDataRead;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_bus_controller #(
        .BYTE_COUNT(4), .ADDRESS_SIZE(4), .BUS_ADDR_SIZE(24), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
        .wb_ack_o(wb_ack_o), .wb_data_o(wb_data_o),
        .clearStart(clearStart), .busy(busy),
        .sramSelect(sramSelect), .sramWriteEnable(sramWriteEnable),
        .sramWriteMask(sramWriteMask), .sramAddress(sramAddress),
        .sramDataWrite(sramDataWrite), .sramDataRead(sramDataRead)
    );

    // SRAM model: masked byte writes, registered read data one cycle after select.
    logic [31:0] mem [16];
    logic [31:0] rd_q = '0;
    assign sramDataRead = rd_q;

    always @(posedge clk) begin
        if (sramSelect) begin
            if (sramWriteEnable) begin
                for (int b = 0; b < 4; b++)
                    if (sramWriteMask[b]) mem[sramAddress][8*b +: 8] <= sramDataWrite[8*b +: 8];
            end else begin
                rd_q <= mem[sramAddress];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction starting in the cycle after the next edge; lat counts edges to ack.
    task automatic bus(input logic we, input logic [23:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic cs,
                       output int lat, output logic [31:0] rdat, output logic sel_seen);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_data_i = dat; wb_sel_i = sel; clearStart = cs;
        lat = 0; rdat = '0; sel_seen = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            sel_seen = sel_seen | sramSelect;
            @(posedge clk);
            lat++;
            #1;
            clearStart = 1'b0;
            if (wb_ack_o) begin
                rdat = wb_data_o;
                break;
            end
        end
        if (!wb_ack_o) chk("ack_timeout", 32'd0, 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    // Follows a running clear from its first word, checking every zero write.
    task automatic clear_watch(output int n);
        n = 0;
        while (busy && n < 40) begin
            chk("clr_adr", 32'(sramAddress), 32'(n));
            chk("clr_ctl", {26'd0, sramSelect, sramWriteEnable, sramWriteMask}, 32'h3F);
            chk("clr_dat", sramDataWrite, 32'd0);
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int          n, lat;
        logic [31:0] rd;
        logic        ss;

        rst = 1'b1; clearStart = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = '0; wb_adr_i = '0; wb_data_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  32'(wb_ack_o), 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_sel",  32'(sramSelect), 32'd0);
        chk("rst_we",   32'(sramWriteEnable), 32'd0);
        chk("rst_adr",  32'(sramAddress), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Clear after reset release
        @(negedge clk); rst = 1'b0; #1;
        clear_watch(n);
        chk("clr_len", 32'(n), 32'd16);
        chk("clr_done", 32'(busy), 32'd0);

        // Full write then read back
        bus(1'b1, 24'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, ss);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_sel", 32'(ss), 32'd1);
        bus(1'b0, 24'h10, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_dat", rd, 32'hDEADBEEF);

        // Byte-masked write
        bus(1'b1, 24'h14, 32'h11223344, 4'hF, 1'b0, lat, rd, ss);
        bus(1'b1, 24'h14, 32'h0000AA00, 4'b0010, 1'b0, lat, rd, ss);
        bus(1'b0, 24'h14, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("mask_dat", rd, 32'h1122AA44);

        // Out-of-range read/write and empty write alias word 4 but must not touch it
        bus(1'b0, 24'h50, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("oor_rd_lat", 32'(lat), 32'd2);
        chk("oor_rd_dat", rd, 32'd0);
        chk("oor_rd_sel", 32'(ss), 32'd0);
        bus(1'b1, 24'h50, 32'h12345678, 4'hF, 1'b0, lat, rd, ss);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_sel", 32'(ss), 32'd0);
        bus(1'b1, 24'h10, 32'hFFFFFFFF, 4'h0, 1'b0, lat, rd, ss);
        chk("nosel_lat", 32'(lat), 32'd1);
        chk("nosel_sel", 32'(ss), 32'd0);
        bus(1'b0, 24'h10, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("keep_dat", rd, 32'hDEADBEEF);

        // Read stalled behind a requested clear
        @(posedge clk); #1; clearStart = 1'b1;
        @(posedge clk); #1; clearStart = 1'b0;
        chk("cs_busy", 32'(busy), 32'd1);
        bus(1'b0, 24'h10, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("stall_lat", 32'(lat), 32'd17);
        chk("stall_dat", rd, 32'd0);
        chk("stall_busy", 32'(busy), 32'd0);

        // Reset in the middle of a clear
        @(posedge clk); #1; clearStart = 1'b1;
        @(posedge clk); #1; clearStart = 1'b0;
        n = 0;
        while (sramAddress != 4'd7 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reach", 32'(n), 32'd7);
        rst = 1'b1; #1;
        chk("mid_sel",  32'(sramSelect), 32'd0);
        chk("mid_adr",  32'(sramAddress), 32'd0);
        chk("mid_ack",  32'(wb_ack_o), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk); rst = 1'b0; #1;
        clear_watch(n);
        chk("reclr_len", 32'(n), 32'd16);

        // clearStart together with a write: write acked first, then the clear runs
        bus(1'b1, 24'h18, 32'hCAFEF00D, 4'hF, 1'b1, lat, rd, ss);
        chk("cw_lat", 32'(lat), 32'd1);
        chk("cw_ackbusy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("cw_busy", 32'(busy), 32'd1);
        clear_watch(n);
        chk("cw_len", 32'(n), 32'd16);
        bus(1'b0, 24'h18, 32'd0, 4'hF, 1'b0, lat, rd, ss);
        chk("cw_dat", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
